// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit stage.
// UART_TX_PARITY_EN adds the even-parity helper used by the 8E1 frame.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction
`endif

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between the UART-to-Wishbone bridge (master) and the TX stage (slave).
interface uart_tx_fifo_if;
  logic [7:0] uart_tx_dat;
  logic       uart_tx_trigger;
  logic       uart_tx_ready_to_send;

  modport master (
    output uart_tx_dat,
    output uart_tx_trigger,
    input  uart_tx_ready_to_send
  );

  modport slave (
    input  uart_tx_dat,
    input  uart_tx_trigger,
    output uart_tx_ready_to_send
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered storage; rd_data always shows the head entry,
// so a consumer can latch it on the same edge that pops it.
module uart_sync_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   wr_data,
  output logic [WIDTH-1:0]   rd_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LEVEL_W-1:0] level_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  // Fullness is judged on the pre-edge level, so a same-edge pop never frees room for a push.
  assign full      = (level_r == LEVEL_W'(DEPTH));
  assign empty     = (level_r == {LEVEL_W{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Storage write port
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LEVEL_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LEVEL_W'(1);
        2'b01:   level_r <= level_r - LEVEL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: 8-entry FIFO feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8,
  parameter int LEVEL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               i_wb_clk,
  input  logic               i_wb_rst,
  uart_tx_fifo_if.slave      tx_bus,
  output logic               o_uart_tx,
  output logic               o_busy,
  output logic [LEVEL_W-1:0] o_fifo_level,
  output logic               o_overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_t              state_r;
  logic [CNT_W-1:0]       baud_cnt_r;
  logic [IDX_W-1:0]       bit_idx_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   tx_r;
  logic                   busy_r;
  logic                   overflow_r;
`ifdef UART_TX_PARITY_EN
  logic                   parity_r;
`endif

  logic                   baud_last_s;
  logic                   fifo_pop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [DATA_BITS-1:0]   fifo_rd_data_s;
  logic [LEVEL_W-1:0]     fifo_level_s;

  uart_sync_fifo #(
    .WIDTH   (DATA_BITS),
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk     (i_wb_clk),
    .rst     (i_wb_rst),
    .push    (tx_bus.uart_tx_trigger),
    .pop     (fifo_pop_s),
    .wr_data (tx_bus.uart_tx_dat),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level_s)
  );

  // Popping on the last STOP cycle chains frames with no idle gap.
  assign baud_last_s = (baud_cnt_r == CNT_W'(CLKS_PER_BIT - 1));
  assign fifo_pop_s  = !fifo_empty_s &&
                       ((state_r == IDLE) || ((state_r == STOP) && baud_last_s));

  assign tx_bus.uart_tx_ready_to_send = !fifo_full_s;
  assign o_uart_tx    = tx_r;
  assign o_busy       = busy_r;
  assign o_fifo_level = fifo_level_s;
  assign o_overflow   = overflow_r;

  // Serialiser FSM, baud counter and registered status flags
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_r    <= IDLE;
      baud_cnt_r <= {CNT_W{1'b0}};
      bit_idx_r  <= {IDX_W{1'b0}};
      shift_r    <= {DATA_BITS{1'b0}};
      tx_r       <= IDLE_LEVEL;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      overflow_r <= tx_bus.uart_tx_trigger && fifo_full_s;
      busy_r     <= (state_r != IDLE) || !fifo_empty_s;

      case (state_r)
        IDLE: begin
          if (fifo_pop_s) begin
            shift_r    <= fifo_rd_data_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= even_parity(fifo_rd_data_s);
`endif
            tx_r       <= START_LEVEL;
            baud_cnt_r <= {CNT_W{1'b0}};
            state_r    <= START;
          end else begin
            tx_r <= IDLE_LEVEL;
          end
        end

        START: begin
          if (baud_last_s) begin
            tx_r       <= shift_r[0];
            baud_cnt_r <= {CNT_W{1'b0}};
            bit_idx_r  <= {IDX_W{1'b0}};
            state_r    <= DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end

        DATA: begin
          if (baud_last_s) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            if (bit_idx_r == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx_r    <= parity_r;
              state_r <= PARITY;
`else
              tx_r    <= IDLE_LEVEL;
              state_r <= STOP;
`endif
            end else begin
              shift_r   <= shift_r >> 1;
              tx_r      <= shift_r[1];
              bit_idx_r <= bit_idx_r + IDX_W'(1);
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last_s) begin
            tx_r       <= IDLE_LEVEL;
            baud_cnt_r <= {CNT_W{1'b0}};
            state_r    <= STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (baud_last_s) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            if (fifo_pop_s) begin
              shift_r  <= fifo_rd_data_s;
`ifdef UART_TX_PARITY_EN
              parity_r <= even_parity(fifo_rd_data_s);
`endif
              tx_r     <= START_LEVEL;
              state_r  <= START;
            end else begin
              tx_r    <= IDLE_LEVEL;
              state_r <= IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end

        default: begin
          tx_r       <= IDLE_LEVEL;
          baud_cnt_r <= {CNT_W{1'b0}};
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level queue model checked every cycle,
// a line decoder, and hand-computed literal expectations.
module tb_uart_tx_fifo;

  localparam int C     = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx;
  logic       busy;
  logic [3:0] level;
  logic       ovf;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_wb_clk     (clk),
    .i_wb_rst     (rst),
    .tx_bus       (bus),
    .o_uart_tx    (tx),
    .o_busy       (busy),
    .o_fifo_level (level),
    .o_overflow   (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Frame as a sequence of line levels: start, data LSB first, [parity], stop.
  function automatic logic [NB-1:0] make_frame(input logic [7:0] b);
    logic [NB-1:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // Model: byte queue plus position within the current frame (-1 = line idle).
  logic [7:0]    mq[$];
  int            fpos = -1;
  logic [NB-1:0] fbits;
  logic          m_tx = 1'b1;
  logic          m_busy = 1'b0;
  logic          m_ovf = 1'b0;
  int            sz;
  bit            do_pop;
  bit            chk_en = 1'b0;
  bit            ovf_seen = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      fpos   = -1;
      m_tx   = 1'b1;
      m_busy = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      sz     = mq.size();
      do_pop = (sz != 0) && (fpos == -1 || fpos == NB * C - 1);
      m_ovf  = bus.uart_tx_trigger && (sz == DEPTH);
      m_busy = (fpos != -1) || (sz != 0);
      if (do_pop) begin
        fbits = make_frame(mq[0]);
        fpos  = 0;
        void'(mq.pop_front());
      end else if (fpos == NB * C - 1) begin
        fpos = -1;
      end else if (fpos != -1) begin
        fpos++;
      end
      if (bus.uart_tx_trigger && sz != DEPTH) mq.push_back(bus.uart_tx_dat);
      m_tx = (fpos < 0) ? 1'b1 : fbits[fpos / C];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_line", 32'(tx), 32'(m_tx));
      check("level", 32'(level), 32'(mq.size()));
      check("ready", 32'(bus.uart_tx_ready_to_send), 32'(mq.size() != DEPTH));
      check("busy", 32'(busy), 32'(m_busy));
      check("overflow", 32'(ovf), 32'(m_ovf));
      if (ovf === 1'b1) ovf_seen = 1'b1;
    end
  end

  // Line decoder: samples each bit in its middle cycle.
  int         rx_pos = -1;
  logic       rx_prev = 1'b1;
  logic [7:0] rx_b;
  logic [7:0] rx_q[$];
  logic       rx_par_q[$];
  logic       rx_p = 1'b0;
  int         idx;

  always @(negedge clk) begin
    if (rst) begin
      rx_pos  = -1;
      rx_prev = 1'b1;
    end else begin
      if (rx_pos < 0) begin
        if (rx_prev && !tx) begin
          rx_pos = 0;
          rx_b   = 8'h00;
        end
      end else begin
        rx_pos++;
        if (rx_pos % C == C / 2) begin
          idx = rx_pos / C;
          if (idx >= 1 && idx <= 8) rx_b[idx-1] = tx;
          if (idx == 9 && NB == 11) rx_p = tx;
          if (idx == NB - 1) begin
            rx_q.push_back(rx_b);
            rx_par_q.push_back(rx_p);
            rx_pos = -1;
          end
        end
      end
      rx_prev = tx;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    step();
    step();
    while ((busy || level != 4'd0) && n < budget) begin
      step();
      n++;
    end
    check(nm, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic       exp41 [NB];
  logic [7:0] dead [8];

  initial begin
`ifdef UART_TX_PARITY_EN
    exp41 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    exp41 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    dead = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};

    // Reset for two edges
    rst = 1'b1;
    bus.uart_tx_trigger = 1'b0;
    bus.uart_tx_dat = 8'h00;
    step();
    step();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(bus.uart_tx_ready_to_send), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single byte 0x41
    bus.uart_tx_trigger = 1'b1;
    bus.uart_tx_dat = 8'h41;
    step();
    bus.uart_tx_trigger = 1'b0;
    check("pre_start_tx", 32'(tx), 32'd1);
    for (int k = 0; k < NB * C; k++) begin
      step();
      if (k % C == C / 2) check("frame41_bit", 32'(tx), 32'(exp41[k / C]));
    end
    step();
    check("busy_after_stop", 32'(busy), 32'd1);
    step();
    check("busy_dropped", 32'(busy), 32'd0);
    check("rx41_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1) check("rx41_byte", 32'(rx_q[0]), 32'h41);
`ifdef UART_TX_PARITY_EN
    if (rx_par_q.size() == 1) check("par41", 32'(rx_par_q[0]), 32'd0);
`endif

    // Ten back-to-back triggers: ninth fills the FIFO, tenth overflows
    rx_q.delete();
    rx_par_q.delete();
    for (int i = 0; i < 10; i++) begin
      bus.uart_tx_trigger = 1'b1;
      bus.uart_tx_dat = 8'h30 + 8'(i);
      step();
      if (i == 8) begin
        check("full_ready", 32'(bus.uart_tx_ready_to_send), 32'd0);
        check("full_level", 32'(level), 32'd8);
      end
      if (i == 9) begin
        check("ovf_pulse", 32'(ovf), 32'd1);
        check("ovf_level", 32'(level), 32'd8);
      end
    end
    bus.uart_tx_trigger = 1'b0;
    step();
    check("ovf_cleared", 32'(ovf), 32'd0);
    wait_idle(1000, "burst_idle_timeout");
    check("burst_count", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      check("burst_byte", 32'(rx_q[i]), 32'h30 + 32'(i));

    // Bridge pattern: trigger every other cycle
    rx_q.delete();
    rx_par_q.delete();
    ovf_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int n = 0;
      while (!bus.uart_tx_ready_to_send && n < 200) begin
        step();
        n++;
      end
      check("bridge_ready_timeout", 32'(n < 200), 32'd1);
      bus.uart_tx_trigger = 1'b1;
      bus.uart_tx_dat = dead[i];
      step();
      bus.uart_tx_trigger = 1'b0;
      step();
    end
    wait_idle(1000, "bridge_idle_timeout");
    check("bridge_no_ovf", 32'(ovf_seen), 32'd0);
    check("bridge_count", 32'(rx_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      check("bridge_byte", 32'(rx_q[i]), 32'(dead[i]));

    // Reset during data bit 3 of 0x55 with three bytes queued
    rx_q.delete();
    rx_par_q.delete();
    for (int i = 0; i < 4; i++) begin
      bus.uart_tx_trigger = 1'b1;
      case (i)
        0:       bus.uart_tx_dat = 8'h55;
        1:       bus.uart_tx_dat = 8'h11;
        2:       bus.uart_tx_dat = 8'h22;
        default: bus.uart_tx_dat = 8'h33;
      endcase
      step();
    end
    bus.uart_tx_trigger = 1'b0;
    repeat (15) step();
    check("mid_level", 32'(level), 32'd3);
    check("mid_bit3", 32'(tx), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("srst_tx", 32'(tx), 32'd1);
    check("srst_level", 32'(level), 32'd0);
    check("srst_ready", 32'(bus.uart_tx_ready_to_send), 32'd1);
    check("srst_busy", 32'(busy), 32'd0);
    repeat (60) step();
    check("post_rst_frames", 32'(rx_q.size()), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_tx", 32'(tx), 32'd1);

`ifdef UART_TX_PARITY_EN
    // Odd number of ones gives parity 1
    rx_q.delete();
    rx_par_q.delete();
    bus.uart_tx_trigger = 1'b1;
    bus.uart_tx_dat = 8'h07;
    step();
    bus.uart_tx_trigger = 1'b0;
    wait_idle(200, "par_idle_timeout");
    check("par07_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1) begin
      check("par07_byte", 32'(rx_q[0]), 32'h07);
      check("par07_bit", 32'(rx_par_q[0]), 32'd1);
    end
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
